// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//
// Two-entry valid/ready pipeline register (head + skid) with stall and flush.
// The skid entry lets the stage keep in_ready high for one extra beat after the
// consumer stalls. This gives one beat per cycle with every output registered.
//
// Ports
//   clk        sole clock, all state updates on the rising edge
//   rst        synchronous active-high reset (wins over flush, hold, push)
//   in_valid   upstream beat present
//   in_ready   stage accepts a beat this cycle (combinational)
//   in_data    upstream payload, sampled only on push
//   in_ctrl    upstream control bits, sampled only on push
//   hold       stall, freezes all stage state and ignores out_ready
//   flush      discards every buffered beat and any beat offered this cycle
//   out_valid  head entry present
//   out_ready  downstream accepts the head beat
//   out_data   head payload, keeps its last value while empty (0 after reset)
//   out_ctrl   head control, BUBBLE_CTRL while empty
//   occupancy  number of buffered beats, 0..2
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           CTRL_WIDTH  = 4,
  parameter logic [CTRL_WIDTH-1:0] BUBBLE_CTRL = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  hold,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic [1:0]            occupancy
);

  logic [1:0]            r_occ;
  logic [DATA_WIDTH-1:0] r_head_data;
  logic [CTRL_WIDTH-1:0] r_head_ctrl;
  logic [DATA_WIDTH-1:0] r_skid_data;
  logic [CTRL_WIDTH-1:0] r_skid_ctrl;

  logic w_in_ready;
  logic w_out_valid;
  logic w_push;
  logic w_pop;

  // A beat offered during reset must be dropped, so rst also drops ready.
  assign w_in_ready  = !rst && (r_occ < 2'd2) && !hold && !flush;
  assign w_out_valid = (r_occ != 2'd0);

  // Because hold and flush are folded in here, the register block below never
  // has to test hold. A held stage simply sees neither a push nor a pop.
  assign w_push = in_valid && w_in_ready;
  assign w_pop  = w_out_valid && out_ready && !hold && !flush;

  // NOTE: all state below uses non-blocking assignments. Every register then
  //       sees the pre-edge values of the others, which makes the skid->head
  //       shift on a pop from a full stage correct whatever the statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the two payload entries are reset here on purpose. out_data must
      //       read 0 after reset and the skid contents are defined to clear,
      //       so this is not a data path that can skip its reset.
      r_occ       <= 2'd0;
      r_head_data <= '0;
      r_head_ctrl <= BUBBLE_CTRL;
      r_skid_data <= '0;
      r_skid_ctrl <= '0;
    end else if (flush) begin
      // Head payload is kept, because out_data is don't-care while empty.
      r_occ       <= 2'd0;
      r_head_ctrl <= BUBBLE_CTRL;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          // A push with no pop fills the head if empty, else the skid.
          if (r_occ == 2'd0) begin
            r_head_data <= in_data;
            r_head_ctrl <= in_ctrl;
            r_occ       <= 2'd1;
          end else begin
            r_skid_data <= in_data;
            r_skid_ctrl <= in_ctrl;
            r_occ       <= 2'd2;
          end
        end
        2'b11: begin
          // A push needs occupancy < 2 and a pop needs occupancy > 0, so this
          // is the occupancy-1 streaming case. The new beat replaces the head.
          r_head_data <= in_data;
          r_head_ctrl <= in_ctrl;
        end
        2'b01: begin
          if (r_occ == 2'd2) begin
            r_head_data <= r_skid_data;
            r_head_ctrl <= r_skid_ctrl;
            r_occ       <= 2'd1;
          end else begin
            // The stage goes empty. Control becomes the bubble value and the
            // payload keeps its last value.
            r_head_ctrl <= BUBBLE_CTRL;
            r_occ       <= 2'd0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_data  = r_head_data;
  assign out_ctrl  = r_head_ctrl;
  assign occupancy = r_occ;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
//
// Drives three instances of pipe_stage_reg in lockstep from the same inputs:
//   - the default 32/4 configuration,
//   - an 8-bit data / 1-bit control instance with BUBBLE_CTRL = 1,
//   - a 64-bit data / 1-bit control instance with BUBBLE_CTRL = 1.
// The expected behaviour comes from a queue model of the stage's rules.
// A directed table covers the streaming, backpressure, hold, flush and reset
// scenarios, and a random phase follows it.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic        hold;
  logic        flush;
  logic [31:0] in_data;
  logic [63:0] in_data64;
  logic [3:0]  in_ctrl;

  logic        in_ready,  out_valid;
  logic [31:0] out_data;
  logic [3:0]  out_ctrl;
  logic [1:0]  occupancy;

  logic        in_ready_w8,  out_valid_w8;
  logic [7:0]  out_data_w8;
  logic [0:0]  out_ctrl_w8;
  logic [1:0]  occupancy_w8;

  logic        in_ready_w64, out_valid_w64;
  logic [63:0] out_data_w64;
  logic [0:0]  out_ctrl_w64;
  logic [1:0]  occupancy_w64;

  pipe_stage_reg dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .hold(hold), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ctrl(out_ctrl), .occupancy(occupancy)
  );

  pipe_stage_reg #(.DATA_WIDTH(8), .CTRL_WIDTH(1), .BUBBLE_CTRL(1'b1)) dut_w8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w8),
    .in_data(in_data[7:0]), .in_ctrl(in_ctrl[0:0]), .hold(hold), .flush(flush),
    .out_valid(out_valid_w8), .out_ready(out_ready), .out_data(out_data_w8),
    .out_ctrl(out_ctrl_w8), .occupancy(occupancy_w8)
  );

  pipe_stage_reg #(.DATA_WIDTH(64), .CTRL_WIDTH(1), .BUBBLE_CTRL(1'b1)) dut_w64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w64),
    .in_data(in_data64), .in_ctrl(in_ctrl[0:0]), .hold(hold), .flush(flush),
    .out_valid(out_valid_w64), .out_ready(out_ready), .out_data(out_data_w64),
    .out_ctrl(out_ctrl_w64), .occupancy(occupancy_w64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: the buffered beats in arrival order, plus the payload the
  // output keeps while the stage is empty.
  typedef struct {
    logic [63:0] d;
    logic [3:0]  c;
  } beat_t;

  beat_t       q[$];
  logic [63:0] m_last = '0;

  typedef struct {
    logic        rst;
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        hold;
    logic        flush;
    logic        rdy;   // in_ready expected during the cycle
    logic [1:0]  occ;   // expected after the edge
    logic        v;
    logic [31:0] data;
  } vec_t;

  vec_t tbl[28];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, check in_ready mid-cycle, clock, update the
  // model, then check every instance's registered outputs.
  task automatic apply(input logic a_rst, input logic a_iv, input logic [31:0] a_d,
                       input logic [3:0] a_c, input logic a_or, input logic a_hold,
                       input logic a_flush, output logic o_rdy);
    beat_t       b;
    logic        exp_rdy, push, pop, exp_v;
    logic [63:0] exp_d;
    logic [3:0]  exp_c;
    rst       = a_rst;
    in_valid  = a_iv;
    in_data   = a_d;
    in_data64 = {a_d ^ 32'hA5A5_A5A5, a_d};
    in_ctrl   = a_c;
    out_ready = a_or;
    hold      = a_hold;
    flush     = a_flush;
    #3;
    exp_rdy = !a_rst && (q.size() < 2) && !a_hold && !a_flush;
    o_rdy   = in_ready;
    check("in_ready",     64'(in_ready),     64'(exp_rdy));
    check("in_ready_w8",  64'(in_ready_w8),  64'(exp_rdy));
    check("in_ready_w64", 64'(in_ready_w64), 64'(exp_rdy));
    push = a_iv && exp_rdy;
    pop  = (q.size() > 0) && a_or && !a_hold && !a_flush && !a_rst;
    @(posedge clk);
    #1;
    if (a_rst) begin
      q.delete();
      m_last = '0;
    end else if (a_flush) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (push) begin
        b.d = in_data64;
        b.c = a_c;
        q.push_back(b);
      end
    end
    if (q.size() > 0) m_last = q[0].d;
    exp_v = (q.size() > 0);
    exp_d = m_last;
    exp_c = exp_v ? q[0].c : 4'h0;
    check("occupancy",     64'(occupancy),     64'(q.size()));
    check("out_valid",     64'(out_valid),     64'(exp_v));
    check("out_data",      64'(out_data),      64'(exp_d[31:0]));
    check("out_ctrl",      64'(out_ctrl),      64'(exp_c));
    check("occupancy_w8",  64'(occupancy_w8),  64'(q.size()));
    check("out_valid_w8",  64'(out_valid_w8),  64'(exp_v));
    check("out_data_w8",   64'(out_data_w8),   64'(exp_d[7:0]));
    check("out_ctrl_w8",   64'(out_ctrl_w8),   exp_v ? 64'(exp_c[0]) : 64'd1);
    check("occupancy_w64", 64'(occupancy_w64), 64'(q.size()));
    check("out_valid_w64", 64'(out_valid_w64), 64'(exp_v));
    check("out_data_w64",  out_data_w64,       exp_d);
    check("out_ctrl_w64",  64'(out_ctrl_w64),  exp_v ? 64'(exp_c[0]) : 64'd1);
  endtask

  initial begin
    logic        rdy;
    logic [31:0] d;

    //                 rst   iv    data      ordy  hold  flush   rdy   occ   v     data
    // reset, with a beat offered that must be dropped
    tbl[0]  = '{1'b1, 1'b1, 32'h42, 1'b0, 1'b0, 1'b0,   1'b0, 2'd0, 1'b0, 32'h0};
    // streaming at one beat per cycle
    tbl[1]  = '{1'b0, 1'b1, 32'h11, 1'b1, 1'b0, 1'b0,   1'b1, 2'd1, 1'b1, 32'h11};
    tbl[2]  = '{1'b0, 1'b1, 32'h22, 1'b1, 1'b0, 1'b0,   1'b1, 2'd1, 1'b1, 32'h22};
    tbl[3]  = '{1'b0, 1'b1, 32'h33, 1'b1, 1'b0, 1'b0,   1'b1, 2'd1, 1'b1, 32'h33};
    tbl[4]  = '{1'b0, 1'b0, 32'hF0, 1'b1, 1'b0, 1'b0,   1'b1, 2'd0, 1'b0, 32'h33};
    // backpressure: 0xC is refused while full
    tbl[5]  = '{1'b0, 1'b1, 32'hA,  1'b0, 1'b0, 1'b0,   1'b1, 2'd1, 1'b1, 32'hA};
    tbl[6]  = '{1'b0, 1'b1, 32'hB,  1'b0, 1'b0, 1'b0,   1'b1, 2'd2, 1'b1, 32'hA};
    tbl[7]  = '{1'b0, 1'b1, 32'hC,  1'b0, 1'b0, 1'b0,   1'b0, 2'd2, 1'b1, 32'hA};
    tbl[8]  = '{1'b0, 1'b0, 32'hC,  1'b1, 1'b0, 1'b0,   1'b0, 2'd1, 1'b1, 32'hB};
    tbl[9]  = '{1'b0, 1'b0, 32'hC,  1'b1, 1'b0, 1'b0,   1'b1, 2'd0, 1'b0, 32'hB};
    // hold for three cycles while full, then drain in order
    tbl[10] = '{1'b0, 1'b1, 32'h5,  1'b0, 1'b0, 1'b0,   1'b1, 2'd1, 1'b1, 32'h5};
    tbl[11] = '{1'b0, 1'b1, 32'h6,  1'b0, 1'b0, 1'b0,   1'b1, 2'd2, 1'b1, 32'h5};
    tbl[12] = '{1'b0, 1'b1, 32'hE7, 1'b1, 1'b1, 1'b0,   1'b0, 2'd2, 1'b1, 32'h5};
    tbl[13] = '{1'b0, 1'b1, 32'hE7, 1'b1, 1'b1, 1'b0,   1'b0, 2'd2, 1'b1, 32'h5};
    tbl[14] = '{1'b0, 1'b1, 32'hE7, 1'b1, 1'b1, 1'b0,   1'b0, 2'd2, 1'b1, 32'h5};
    tbl[15] = '{1'b0, 1'b0, 32'hE7, 1'b1, 1'b0, 1'b0,   1'b0, 2'd1, 1'b1, 32'h6};
    tbl[16] = '{1'b0, 1'b0, 32'hE7, 1'b1, 1'b0, 1'b0,   1'b1, 2'd0, 1'b0, 32'h6};
    // flush while full drops 0x77; then flush together with hold
    tbl[17] = '{1'b0, 1'b1, 32'h7,  1'b0, 1'b0, 1'b0,   1'b1, 2'd1, 1'b1, 32'h7};
    tbl[18] = '{1'b0, 1'b1, 32'h8,  1'b0, 1'b0, 1'b0,   1'b1, 2'd2, 1'b1, 32'h7};
    tbl[19] = '{1'b0, 1'b1, 32'h77, 1'b1, 1'b0, 1'b1,   1'b0, 2'd0, 1'b0, 32'h7};
    tbl[20] = '{1'b0, 1'b1, 32'h9,  1'b0, 1'b0, 1'b0,   1'b1, 2'd1, 1'b1, 32'h9};
    tbl[21] = '{1'b0, 1'b1, 32'h77, 1'b0, 1'b1, 1'b1,   1'b0, 2'd0, 1'b0, 32'h9};
    tbl[22] = '{1'b0, 1'b0, 32'h77, 1'b1, 1'b0, 1'b0,   1'b1, 2'd0, 1'b0, 32'h9};
    // reset while full, then the first push becomes the sole head
    tbl[23] = '{1'b0, 1'b1, 32'hA1, 1'b0, 1'b0, 1'b0,   1'b1, 2'd1, 1'b1, 32'hA1};
    tbl[24] = '{1'b0, 1'b1, 32'hA2, 1'b0, 1'b0, 1'b0,   1'b1, 2'd2, 1'b1, 32'hA1};
    tbl[25] = '{1'b1, 1'b1, 32'hA3, 1'b0, 1'b0, 1'b0,   1'b0, 2'd0, 1'b0, 32'h0};
    tbl[26] = '{1'b0, 1'b1, 32'h99, 1'b0, 1'b0, 1'b0,   1'b1, 2'd1, 1'b1, 32'h99};
    tbl[27] = '{1'b0, 1'b0, 32'h99, 1'b1, 1'b0, 1'b0,   1'b1, 2'd0, 1'b0, 32'h99};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_data64 = '0; in_ctrl = '0;
    out_ready = 1'b0; hold = 1'b0; flush = 1'b0;
    @(posedge clk);
    #1;

    // Control equals the low data nibble, so the expected head control
    // follows from the expected head data.
    for (int i = 0; i < 28; i++) begin
      d = tbl[i].d;
      apply(tbl[i].rst, tbl[i].iv, d, d[3:0], tbl[i].ordy, tbl[i].hold, tbl[i].flush, rdy);
      d = tbl[i].data;
      check($sformatf("row%0d in_ready", i),  64'(rdy),         64'(tbl[i].rdy));
      check($sformatf("row%0d occupancy", i), 64'(occupancy),   64'(tbl[i].occ));
      check($sformatf("row%0d out_valid", i), 64'(out_valid),   64'(tbl[i].v));
      check($sformatf("row%0d out_data", i),  64'(out_data),    64'(tbl[i].data));
      check($sformatf("row%0d out_ctrl", i),  64'(out_ctrl),    tbl[i].v ? 64'(d[3:0]) : 64'h0);
      check($sformatf("row%0d ctrl_w8", i),   64'(out_ctrl_w8), tbl[i].v ? 64'(d[0]) : 64'h1);
    end

    // Random traffic checked against the queue model.
    for (int n = 0; n < 3000; n++) begin
      apply($urandom_range(0, 63) == 0,
            $urandom_range(0, 9) < 7,
            $urandom,
            4'($urandom_range(0, 15)),
            $urandom_range(0, 9) < 6,
            $urandom_range(0, 7) == 0,
            $urandom_range(0, 15) == 0,
            rdy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, payload width in bits.
REQ-002 Parameter: CTRL_WIDTH, default 4, control-bit width; control is replaced by bubble value when the stage is empty.
REQ-003 Parameter: BUBBLE_CTRL, default 0 (CTRL_WIDTH bits), control value driven when out_valid=0.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  upstream beat present.
REQ-007 in_ready  output  1  stage accepts a beat this cycle.
REQ-008 in_data  input  DATA_WIDTH  upstream payload.
REQ-009 in_ctrl  input  CTRL_WIDTH  upstream control bits.
REQ-010 hold  input  1  stall: freezes all stage state.
REQ-011 flush  input  1  discard all buffered beats.
REQ-012 out_valid  output  1  downstream beat present.
REQ-013 out_ready  input  1  downstream accepts beat.
REQ-014 out_data  output  DATA_WIDTH  head payload.
REQ-015 out_ctrl  output  CTRL_WIDTH  head control, or BUBBLE_CTRL when out_valid=0.
REQ-016 occupancy  output  2  number of buffered beats, 0..2.

Function
REQ-017 Storage SHALL be two entries (head, skid) in FIFO order; no beat reordered, duplicated or lost except by flush/reset.
REQ-018 in_ready SHALL equal (occupancy<2) AND NOT hold AND NOT flush, combinationally.
REQ-019 Push SHALL occur when in_valid AND in_ready; pop SHALL occur when out_valid AND out_ready AND NOT hold AND NOT flush.
REQ-020 out_valid SHALL equal (occupancy>0); out_data/out_ctrl SHALL present head entry, registered (no combinational in->out path).
REQ-021 Latency: beat pushed into empty stage SHALL appear at out_valid on the next cycle.
REQ-022 Push and pop same cycle, occupancy 1: occupancy stays 1, new beat becomes head next cycle; full throughput of one beat/cycle.
REQ-023 Pop at occupancy 2: skid moves to head, occupancy becomes 1; no push possible that cycle (in_ready=0).
REQ-024 Push with no pop: occupancy increments; into skid if head valid, else head.
REQ-025 Pop with no push: occupancy decrements.
REQ-026 hold=1: occupancy, head, skid SHALL be unchanged; outputs stable; out_ready ignored.
REQ-027 flush=1: next cycle occupancy=0, out_valid=0, out_ctrl=BUBBLE_CTRL; simultaneous in_valid beat SHALL be dropped; flush has priority over hold, push, pop.
REQ-028 When out_valid=0, out_ctrl SHALL equal BUBBLE_CTRL; out_data SHALL retain last value (don't-care for consumers) except after reset.
REQ-029 in_data/in_ctrl SHALL be sampled only on push; values on non-push cycles SHALL have no effect.

Reset
REQ-030 rst=1 SHALL at next edge set occupancy=0, out_valid=0, out_data=0, out_ctrl=BUBBLE_CTRL, skid contents=0; priority over flush, hold, push.
REQ-031 While rst=1, in_ready SHALL be 0; a beat offered during reset SHALL be dropped.
REQ-032 Reset mid-operation with occupancy 2 SHALL discard both beats; first post-reset push SHALL appear as sole head.

Verification
REQ-033 Stream: out_ready=1, push 0x11,0x22,0x33 consecutive cycles -> out_data 0x11,0x22,0x33 on cycles 1,2,3, occupancy 1 throughout, in_ready=1 always.
REQ-034 Backpressure: out_ready=0, push 0xA,0xB,0xC -> occupancy 1,2,2, in_ready=0 at occupancy 2, 0xC not accepted; raise out_ready -> 0xA then 0xB popped, occupancy 2->1->0.
REQ-035 Hold: occupancy 2 (0x5,0x6), hold=1 for 3 cycles with out_ready=1, in_valid=1 -> occupancy stays 2, out_data=0x5, in_ready=0; release -> 0x5,0x6 delivered in order.
REQ-036 Flush: occupancy 2, flush=1 with in_valid=1 in_data=0x77 -> next cycle occupancy=0, out_valid=0, out_ctrl=BUBBLE_CTRL, 0x77 never appears; flush+hold together -> flush wins.
REQ-037 Reset: occupancy 2, rst=1 one cycle -> out_valid=0, out_data=0, out_ctrl=BUBBLE_CTRL, occupancy=0; push 0x99 next -> out_data=0x99 one cycle later.
REQ-038 Parameter sweep: DATA_WIDTH=8 and 64, CTRL_WIDTH=1, BUBBLE_CTRL=1 -> REQ-033..037 pass; out_ctrl=1 whenever empty.
